// File: rtl/mem_req_ctrl.sv
// Upstream request sequencer: arbitrates fetch vs MEM-stage accesses and issues
// one token-tagged request at a time toward the RAM1/UART memory controller.
module mem_req_ctrl #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int ACT_W   = 32,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              ex_rd,
  input  logic              ex_wr,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_wdata,
  output logic [DATA_W-1:0] ex_rdata,
  output logic              ex_ready,
  output logic              mem_need,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_value,
  output logic [ACT_W-1:0]  mem_act,
  input  logic [ACT_W-1:0]  mem_act_ack,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_result,
  output logic              stall,
  output logic              timeout_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam bit          TIMEOUT_EN   = (TIMEOUT != 0);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT - 1);

  state_t      state;
  logic        owner_ex;
  logic        req_rd;
  logic        req_wr;
  logic [31:0] wait_cnt;
  logic        acked;
  logic        timed_out;

  // A done strobe only counts when it carries the token of the request in flight.
  assign acked     = mem_done && (mem_act_ack == mem_act);
  assign timed_out = TIMEOUT_EN && (wait_cnt == TIMEOUT_LAST);

  assign stall = (state == ISSUE) || (state == WAIT) ||
                 ((state == IDLE) && (ex_rd || ex_wr || if_req));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      owner_ex    <= 1'b0;
      req_rd      <= 1'b0;
      req_wr      <= 1'b0;
      wait_cnt    <= '0;
      mem_need    <= 1'b0;
      mem_rd      <= 1'b0;
      mem_wr      <= 1'b0;
      mem_addr    <= '0;
      mem_value   <= '0;
      mem_act     <= '0;
      if_rdata    <= '0;
      ex_rdata    <= '0;
      if_ready    <= 1'b0;
      ex_ready    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if_ready <= 1'b0;
      ex_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (ex_wr || ex_rd) begin
            owner_ex  <= 1'b1;
            req_wr    <= ex_wr;
            req_rd    <= ~ex_wr;
            mem_addr  <= ex_addr;
            mem_value <= ex_wdata;
            state     <= ISSUE;
          end else if (if_req) begin
            owner_ex <= 1'b0;
            req_wr   <= 1'b0;
            req_rd   <= 1'b1;
            mem_addr <= if_addr;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          // Token 0 is reserved, so the counter wraps from all-ones back to 1.
          mem_act  <= (mem_act == {ACT_W{1'b1}}) ? ACT_W'(1) : mem_act + ACT_W'(1);
          mem_need <= 1'b1;
          mem_rd   <= req_rd;
          mem_wr   <= req_wr;
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          // A timeout still passes through RESP so the requester sees a clean
          // one-cycle ready before IDLE samples its (dropped) request again.
          if (acked || timed_out) begin
            mem_need <= 1'b0;
            mem_rd   <= 1'b0;
            mem_wr   <= 1'b0;
            if (!acked) timeout_err <= 1'b1;
            if (owner_ex) begin
              ex_rdata <= acked ? mem_result : {DATA_W{1'b1}};
              ex_ready <= 1'b1;
            end else begin
              if_rdata <= acked ? mem_result : {DATA_W{1'b1}};
              if_ready <= 1'b1;
            end
            state <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed bench for mem_req_ctrl: a vector table of single accesses plus
// hand-written sequences for arbitration, stale acks, timeout and async reset.
module tb_mem_req_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [15:0] if_addr;
  logic        ex_rd;
  logic        ex_wr;
  logic [15:0] ex_addr;
  logic [15:0] ex_wdata;
  logic [31:0] mem_act_ack;
  logic        mem_done;
  logic [15:0] mem_result;

  logic [15:0] if_rdata, ex_rdata, mem_addr, mem_value;
  logic        if_ready, ex_ready, mem_need, mem_rd, mem_wr, stall, timeout_err;
  logic [31:0] mem_act;

  logic [15:0] s_if_rdata, s_ex_rdata, s_mem_addr, s_mem_value;
  logic        s_if_ready, s_ex_ready, s_mem_need, s_mem_rd, s_mem_wr, s_stall, s_timeout_err;
  logic [1:0]  s_mem_act;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_req_ctrl #(.ADDR_W(16), .DATA_W(16), .ACT_W(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .ex_rd(ex_rd), .ex_wr(ex_wr), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .ex_rdata(ex_rdata), .ex_ready(ex_ready),
    .mem_need(mem_need), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_value(mem_value), .mem_act(mem_act), .mem_act_ack(mem_act_ack),
    .mem_done(mem_done), .mem_result(mem_result),
    .stall(stall), .timeout_err(timeout_err)
  );

  // Narrow-token copy that always acknowledges its own token, used to see wrap-around.
  mem_req_ctrl #(.ADDR_W(16), .DATA_W(16), .ACT_W(2), .TIMEOUT(0)) dut_small (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(s_if_rdata), .if_ready(s_if_ready),
    .ex_rd(ex_rd), .ex_wr(ex_wr), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .ex_rdata(s_ex_rdata), .ex_ready(s_ex_ready),
    .mem_need(s_mem_need), .mem_rd(s_mem_rd), .mem_wr(s_mem_wr), .mem_addr(s_mem_addr),
    .mem_value(s_mem_value), .mem_act(s_mem_act), .mem_act_ack(s_mem_act),
    .mem_done(mem_done), .mem_result(mem_result),
    .stall(s_stall), .timeout_err(s_timeout_err)
  );

  typedef struct {
    logic        ex_rd;
    logic        ex_wr;
    logic        if_req;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] result;
    int          delay;
    logic        exp_rd;
    logic        exp_wr;
    logic [15:0] exp_value;
    logic        chk_value;
    logic [31:0] exp_act;
    logic [1:0]  exp_small_act;
  } vec_t;

  vec_t vecs[4];

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    ex_rd    = v.ex_rd;
    ex_wr    = v.ex_wr;
    if_req   = v.if_req;
    ex_addr  = v.if_req ? ~v.addr : v.addr;
    if_addr  = v.if_req ? v.addr : ~v.addr;
    ex_wdata = v.wdata;
  endtask

  task automatic drop_requests();
    ex_rd  = 1'b0;
    ex_wr  = 1'b0;
    if_req = 1'b0;
  endtask

  task automatic do_reset();
    drop_requests();
    if_addr = '0; ex_addr = '0; ex_wdata = '0;
    mem_act_ack = '0; mem_done = 1'b0; mem_result = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_for_need();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_need) break;
    end
    check_output("mem_need seen", mem_need, 1);
  endtask

  task automatic finish_txn(input bit want_ex, input logic [15:0] result, input int delay,
                            input logic [31:0] ack, input logic [15:0] exp_rdata);
    logic rdy;
    repeat (delay) @(negedge clk);
    mem_result  = result;
    mem_act_ack = ack;
    mem_done    = 1'b1;
    rdy = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      rdy = want_ex ? ex_ready : if_ready;
      if (rdy) break;
    end
    check_output("ready seen", rdy, 1);
    check_output("rdata", want_ex ? ex_rdata : if_rdata, exp_rdata);
    check_output("other ready idle", want_ex ? if_ready : ex_ready, 0);
    check_output("mem_need dropped", mem_need, 0);
    check_output("stall in RESP", stall, 0);
    mem_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{1'b0, 1'b1, 1'b0, 16'h4000, 16'h1234, 16'hBEEF, 4,
                1'b0, 1'b1, 16'h1234, 1'b1, 32'd1, 2'd1};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 16'h0123, 16'h7777, 16'h5A5A, 0,
                1'b1, 1'b0, 16'h7777, 1'b1, 32'd2, 2'd2};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 16'h00FF, 16'h0000, 16'hC0DE, 2,
                1'b1, 1'b0, 16'h0000, 1'b0, 32'd3, 2'd3};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1,
                1'b0, 1'b1, 16'h0001, 1'b1, 32'd4, 2'd1};

    do_reset();
    check_output("reset mem_need", mem_need, 0);
    check_output("reset mem_rd", mem_rd, 0);
    check_output("reset mem_wr", mem_wr, 0);
    check_output("reset mem_act", mem_act, 0);
    check_output("reset mem_addr", mem_addr, 0);
    check_output("reset ready", {if_ready, ex_ready}, 0);
    check_output("reset rdata", {if_rdata, ex_rdata}, 0);
    check_output("reset timeout_err", timeout_err, 0);
    check_output("reset stall", stall, 0);

    // Single accesses; the narrow copy wraps its token from 3 to 1.
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(vecs[i]);
      #1;
      check_output($sformatf("v%0d stall idle", i), stall, 1);
      wait_for_need();
      check_output($sformatf("v%0d mem_rd", i), mem_rd, vecs[i].exp_rd);
      check_output($sformatf("v%0d mem_wr", i), mem_wr, vecs[i].exp_wr);
      check_output($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].addr);
      if (vecs[i].chk_value)
        check_output($sformatf("v%0d mem_value", i), mem_value, vecs[i].exp_value);
      check_output($sformatf("v%0d mem_act", i), mem_act, vecs[i].exp_act);
      check_output($sformatf("v%0d small act", i), s_mem_act, vecs[i].exp_small_act);
      check_output($sformatf("v%0d stall wait", i), stall, 1);
      finish_txn(vecs[i].ex_rd | vecs[i].ex_wr, vecs[i].result, vecs[i].delay,
                 vecs[i].exp_act, vecs[i].result);
      drop_requests();
      @(negedge clk);
      check_output($sformatf("v%0d ready pulse", i), {if_ready, ex_ready}, 0);
    end

    // EX and IF requested together: EX first, then IF.
    do_reset();
    ex_rd = 1'b1; ex_addr = 16'h1111; if_req = 1'b1; if_addr = 16'h2222;
    wait_for_need();
    check_output("tie ex addr", mem_addr, 16'h1111);
    check_output("tie ex act", mem_act, 1);
    finish_txn(1'b1, 16'hAAAA, 0, 32'd1, 16'hAAAA);
    ex_rd = 1'b0;
    wait_for_need();
    check_output("tie if addr", mem_addr, 16'h2222);
    check_output("tie if act", mem_act, 2);
    check_output("tie if mem_rd", mem_rd, 1);
    finish_txn(1'b0, 16'hBBBB, 0, 32'd2, 16'hBBBB);
    if_req = 1'b0;
    @(negedge clk);

    // Stale token is ignored; request dropped mid-flight still completes.
    ex_rd = 1'b1; ex_addr = 16'h2468;
    wait_for_need();
    check_output("stale act", mem_act, 3);
    mem_result = 16'h1357; mem_act_ack = 32'd2; mem_done = 1'b1;
    ex_rd = 1'b0; ex_addr = 16'h9999;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output("stale no ready", ex_ready, 0);
      check_output("stale need held", mem_need, 1);
    end
    check_output("stale addr frozen", mem_addr, 16'h2468);
    check_output("stale rd frozen", mem_rd, 1);
    mem_act_ack = 32'd3;
    @(negedge clk);
    check_output("stale then ack ready", ex_ready, 1);
    check_output("stale then ack rdata", ex_rdata, 16'h1357);
    mem_done = 1'b0;
    @(negedge clk);

    // Controller never answers: timeout after 16 WAIT cycles.
    ex_rd = 1'b1; ex_addr = 16'h3333;
    wait_for_need();
    check_output("to act", mem_act, 4);
    repeat (15) @(negedge clk);
    check_output("to not yet", timeout_err, 0);
    check_output("to need at 16", mem_need, 1);
    @(negedge clk);
    check_output("to err set", timeout_err, 1);
    check_output("to ready", ex_ready, 1);
    check_output("to rdata", ex_rdata, 16'hFFFF);
    check_output("to need dropped", mem_need, 0);
    ex_rd = 1'b0;
    @(negedge clk);
    check_output("to sticky", timeout_err, 1);

    // Asynchronous reset in the middle of WAIT.
    ex_wr = 1'b1; ex_addr = 16'h5555; ex_wdata = 16'hAAAA;
    wait_for_need();
    check_output("rst pre act", mem_act, 5);
    check_output("rst pre wr", mem_wr, 1);
    #2 rst = 1'b1;
    #1;
    check_output("rst async need", mem_need, 0);
    check_output("rst async wr", mem_wr, 0);
    check_output("rst async act", mem_act, 0);
    check_output("rst async addr", mem_addr, 0);
    check_output("rst async value", mem_value, 0);
    check_output("rst async rdata", ex_rdata, 0);
    check_output("rst async err", timeout_err, 0);
    ex_wr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    ex_rd = 1'b1; ex_addr = 16'h0042;
    wait_for_need();
    check_output("post rst act", mem_act, 1);
    finish_txn(1'b1, 16'h4242, 0, 32'd1, 16'h4242);
    ex_rd = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
